// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller for a shared datapath: registered one-hot grant,
// bounded hold time, and one dead cycle between owners so the shared DFF stage settles.
module rr_grant_ctrl #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] idx;
  } arb_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic              timeout_q, timeout_d;
  logic              busy_q, busy_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  arb_t arb;
  logic owner_req;
  logic at_limit;

  // First requester at or after ptr, wrapping modulo N_REQ.
  function automatic arb_t pick(input logic [N_REQ-1:0] r, input logic [ID_W-1:0] p);
    arb_t res;
    int   j;
    res = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(p) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!res.found && r[j]) begin
        res.found = 1'b1;
        res.idx   = j[ID_W-1:0];
      end
    end
    return res;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    arb        = pick(req, ptr_q);
    owner_req  = req[gnt_id_q];
    at_limit   = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));

    case (state_q)
      IDLE, RELEASE: begin
        if (arb.found) begin
          state_d    = GRANT;
          gnt_d      = onehot(arb.idx);
          gnt_id_d   = arb.idx;
          hold_cnt_d = '0;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      GRANT: begin
        if (done || !owner_req || at_limit) begin
          state_d   = RELEASE;
          gnt_d     = '0;
          ptr_d     = (int'(gnt_id_q) == N_REQ - 1) ? '0 : gnt_id_q + 1'b1;
          // done and a dropped request both take precedence over the hold limit
          timeout_d = at_limit && !done && owner_req;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    gnt_valid_d = |gnt_d;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign timeout   = timeout_q;
  assign busy      = busy_q;

endmodule

// File: doc/rr_grant_ctrl.md
Name: rr_grant_ctrl

Overview:
- Round-robin controller that shares one gate-level datapath (built from the team's BUF/NOT/NAND/NOR/DFF cell library) among N requesters.
- Issues a registered one-hot grant and holds it until the owner signals done, drops its request, or exceeds a maximum hold time.
- Enforces one dead cycle between owners so the shared datapath's DFF stage (2-unit clock-to-Q) settles before handover.
- Sits between requester FSMs and the shared datapath's input mux select.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of gnt_id; must satisfy 2^ID_W >= N_REQ.
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant (1..15).
- HOLD_W, 4, hold counter width; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  request vector; bit i is requester i.
- done  in  1  the current owner has finished its transaction; sampled only in GRANT.
- gnt  out  N_REQ  one-hot grant, registered.
- gnt_valid  out  1  OR of gnt, registered.
- gnt_id  out  ID_W  index of the current owner; holds the last owner when gnt_valid=0.
- timeout  out  1  one-cycle pulse: the last grant was revoked by MAX_HOLD.
- busy  out  1  high in GRANT and RELEASE states.

Behaviour:
- Reset, asynchronous and immediate, even mid-grant: state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, timeout=0, busy=0, ptr=0, hold_cnt=0.
- States: IDLE, GRANT, RELEASE.
- Arbitration function: winner = first index j scanning ptr, ptr+1, ..., wrapping modulo N_REQ, with req[j]=1.
- IDLE, req != 0 at edge: go to GRANT. gnt[winner]=1, gnt_id=winner, hold_cnt=0.
- IDLE, req == 0: stay in IDLE.
- Latency: req asserted before edge k gives gnt visible after edge k, i.e. one cycle.
- GRANT: hold_cnt increments every cycle. Release at the edge where any of these hold:
  - (a) done=1;
  - (b) req[gnt_id]=0;
  - (c) hold_cnt == MAX_HOLD-1.
- On release: go to RELEASE. gnt=0, gnt_valid=0, ptr=(gnt_id+1) mod N_REQ.
- timeout=1 during the RELEASE cycle only if (c) caused the release and neither (a) nor (b) held on the same edge. done has priority: simultaneous done and limit gives timeout=0.
- A grant therefore lasts at most MAX_HOLD cycles.
- RELEASE lasts exactly one cycle (the dead cycle, gnt=0). At its exit edge, run arbitration with the updated ptr: go to GRANT if req != 0, else IDLE.
- Minimum gap between consecutive grants is one cycle.
- A requester revoked by timeout that still requests is lowest priority in the next arbitration. It may regain the grant only if no other request is pending.
- done outside GRANT is ignored.
- req changes of non-owners during GRANT do not affect the current grant.
- ptr wraps from N_REQ-1 to 0.
- Invariants checked by the bench:
  - gnt is always one-hot or zero;
  - gnt_valid == |gnt;
  - timeout is never high in two consecutive cycles;
  - busy == (state != IDLE).

Test Plan:
- Reset mid-grant: req=4'b0001, grant held 3 cycles, then assert reset between edges -> gnt=0 and gnt_valid=0 immediately, no clock edge needed; after release, req=4'b0001 -> gnt=4'b0001 one cycle later.
- Round-robin rotation: req=4'b1111 held, done pulsed one cycle after each grant -> grant sequence 0001, dead, 0010, dead, 0100, dead, 1000, dead, 0001; gnt_id = 0, 1, 2, 3, 0.
- Timeout: req=4'b0011, no done -> gnt=0001 for exactly 8 cycles, timeout=1 in the next cycle, then gnt=0010.
- Done coincident with limit: done=1 on the 8th grant cycle -> release, timeout stays 0.
- Owner drops request: req 4'b0100 -> 4'b0000 after 2 grant cycles -> gnt=0 at next edge, then RELEASE, then IDLE, busy=0.
- Wrap and skip: ptr=3 (last owner 2), req=4'b0010 -> winner is 1, gnt=0010, gnt_id=1, and requester 3's absence is skipped.
